// File: rtl/xmm_fixed_point_unit.sv
// Multi-cycle signed Q-format add/sub/mul/div unit feeding the XMM write-select fpu_res source.
// Operands are reduced to sign + magnitude; mul is shift-add, div is restoring, and results saturate.
module xmm_fixed_point_unit #(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] fpu_res,
    output logic             ovf,
    output logic             dz
);

    localparam int QW = WIDTH + FRAC_BITS;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam logic [CW-1:0] LAST_ADD = '0;
    localparam logic [CW-1:0] LAST_MUL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_DIV = CW'(QW - 1);

    localparam logic [WIDTH-1:0] POS_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    POS_LIMIT = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [PW-1:0]    NEG_LIMIT = POS_LIMIT + PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] aOp_q, aOp_d;
    logic [WIDTH-1:0] bOp_q, bOp_d;
    logic             signA_q, signA_d;
    logic             signB_q, signB_d;
    logic [WIDTH-1:0] magB_q, magB_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [QW-1:0]    quot_q, quot_d;
    logic [WIDTH-1:0] fpu_res_q, fpu_res_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] aMag, bMag;
    logic [PW-1:0]    stepAcc;
    logic [WIDTH:0]   trial;
    logic             trialGe;
    logic [WIDTH-1:0] stepRem;
    logic [QW-1:0]    stepQuot;
    logic [WIDTH+1:0] sumExt, sumMag;
    logic             sumNeg;
    logic             lastIter;
    logic             rNeg, isDz;
    logic [PW-1:0]    rMag;
    logic [WIDTH-1:0] satRes;
    logic             satOvf;

    assign aMag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign bMag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    // One multiplier bit per cycle, LSB first, with the multiplicand walking left.
    assign stepAcc = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Restoring division: the remainder stays below |b|, so it fits in WIDTH bits.
    assign trial    = {rem_q, quot_q[QW-1]};
    assign trialGe  = trial >= {1'b0, magB_q};
    assign stepRem  = trialGe ? WIDTH'(trial - {1'b0, magB_q}) : trial[WIDTH-1:0];
    assign stepQuot = {quot_q[QW-2:0], trialGe};

    assign sumExt = (op_q == OP_SUB)
                  ? ({{2{aOp_q[WIDTH-1]}}, aOp_q} - {{2{bOp_q[WIDTH-1]}}, bOp_q})
                  : ({{2{aOp_q[WIDTH-1]}}, aOp_q} + {{2{bOp_q[WIDTH-1]}}, bOp_q});
    assign sumNeg = sumExt[WIDTH+1];
    assign sumMag = sumNeg ? (~sumExt + (WIDTH+2)'(1)) : sumExt;

    always_comb begin
        lastIter = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: lastIter = (cnt_q == LAST_ADD);
            OP_MUL:         lastIter = (cnt_q == LAST_MUL);
            default:        lastIter = (cnt_q == LAST_DIV);
        endcase
    end

    // The final result is taken from the step values so it is ready on the edge into FIN.
    always_comb begin
        rNeg   = 1'b0;
        rMag   = '0;
        isDz   = 1'b0;
        satRes = '0;
        satOvf = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                rNeg = sumNeg;
                rMag = PW'(sumMag);
            end
            OP_MUL: begin
                rNeg = signA_q ^ signB_q;
                rMag = stepAcc >> FRAC_BITS;
            end
            default: begin
                isDz = (magB_q == '0);
                rNeg = isDz ? signA_q : (signA_q ^ signB_q);
                rMag = PW'(stepQuot);
            end
        endcase
        if (isDz) begin
            satRes = rNeg ? NEG_MAX : POS_MAX;
            satOvf = 1'b1;
        end else if (rNeg) begin
            if (rMag > NEG_LIMIT) begin
                satRes = NEG_MAX;
                satOvf = 1'b1;
            end else begin
                satRes = ~rMag[WIDTH-1:0] + WIDTH'(1);
            end
        end else begin
            if (rMag > POS_LIMIT) begin
                satRes = POS_MAX;
                satOvf = 1'b1;
            end else begin
                satRes = rMag[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        aOp_d     = aOp_q;
        bOp_d     = bOp_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        magB_d    = magB_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        fpu_res_d = fpu_res_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    op_d     = op;
                    aOp_d    = a;
                    bOp_d    = b;
                    signA_d  = a[WIDTH-1];
                    signB_d  = b[WIDTH-1];
                    magB_d   = bMag;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, aMag};
                    mplier_d = bMag;
                    rem_d    = '0;
                    quot_d   = {aMag, {FRAC_BITS{1'b0}}};
                end
            end
            CALC: begin
                cnt_d    = cnt_q + CW'(1);
                acc_d    = stepAcc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                rem_d    = stepRem;
                quot_d   = stepQuot;
                if (lastIter) begin
                    state_d   = FIN;
                    fpu_res_d = satRes;
                    ovf_d     = satOvf;
                    dz_d      = isDz;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            aOp_q     <= '0;
            bOp_q     <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            magB_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            fpu_res_q <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            op_q      <= op_d;
            aOp_q     <= aOp_d;
            bOp_q     <= bOp_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            magB_q    <= magB_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            fpu_res_q <= fpu_res_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign fpu_res = fpu_res_q;
    assign ovf     = ovf_q;
    assign dz      = dz_q;

endmodule

// File: tb/tb_xmm_fixed_point_unit.sv
// Scoreboard bench for xmm_fixed_point_unit: directed operations push expected results,
// a monitor pops them on done and also watches reset, busy and result hold behaviour.
module tb_xmm_fixed_point_unit;

    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam int LAT_ADD = 2;
    localparam int LAT_MUL = 65;
    localparam int LAT_DIV = 80;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic        dz;
        int          startCycle;
        int          expCycle;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] fpu_res;
    logic        ovf;
    logic        dz;

    exp_t sb[$];
    int   cycleCnt = 0;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] lastRes = '0;

    xmm_fixed_point_unit #(.WIDTH(64), .FRAC_BITS(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .fpu_res (fpu_res),
        .ovf     (ovf),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Only the monitor process touches the check counters.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cycleCnt);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_done", 64'(done), 64'd0);
                checkOutput("rst_res", fpu_res, 64'd0);
                checkOutput("rst_flags", 64'({ovf, dz}), 64'd0);
                sb.delete();
                lastRes = '0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cycleCnt);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_res"}, fpu_res, e.res);
                    checkOutput({e.name, "_ovf"}, 64'(ovf), 64'(e.ovf));
                    checkOutput({e.name, "_dz"}, 64'(dz), 64'(e.dz));
                    checkOutput({e.name, "_lat"}, 64'(cycleCnt), 64'(e.expCycle));
                    lastRes = fpu_res;
                end
            end else if (sb.size() != 0) begin
                if (cycleCnt > sb[0].expCycle) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s_timeout: got no done by cycle %0d expected done at %0d",
                             sb[0].name, cycleCnt, sb[0].expCycle);
                    void'(sb.pop_front());
                end else if (cycleCnt > sb[0].startCycle) begin
                    checkOutput({sb[0].name, "_busy"}, 64'(busy), 64'd1);
                    checkOutput({sb[0].name, "_hold"}, fpu_res, lastRes);
                end
            end
        end
    end

    task automatic waitIdle();
        int waited = 0;
        @(negedge clk);
        while ((busy || done) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] opV, input logic [63:0] aV,
                                 input logic [63:0] bV, input logic [63:0] expRes,
                                 input logic expOvf, input logic expDz, input int lat);
        exp_t e;
        waitIdle();
        start = 1'b1;
        op    = opV;
        a     = aV;
        b     = bV;
        e.res        = expRes;
        e.ovf        = expOvf;
        e.dz         = expDz;
        e.startCycle = cycleCnt;
        e.expCycle   = cycleCnt + lat;
        e.name       = name;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin : stimulus
        int waited;
        rst_n = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("add_ovf", 2'b00, MAXV, 64'd1, MAXV, 1'b1, 1'b0, LAT_ADD);
        applyStimulus("sub_neg", 2'b01, 64'h8000, 64'hC000, 64'hFFFF_FFFF_FFFF_C000, 1'b0, 1'b0, LAT_ADD);
        applyStimulus("sub_minus1", 2'b01, MINV, 64'd1, MINV, 1'b1, 1'b0, LAT_ADD);
        applyStimulus("sub_negmin", 2'b01, 64'd0, MINV, MAXV, 1'b1, 1'b0, LAT_ADD);

        // Abort a division with reset in the middle of its iterations.
        waitIdle();
        start = 1'b1;
        op    = 2'b11;
        a     = 64'h8000;
        b     = 64'h10000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("mul_one", 2'b10, 64'h8000, 64'h8000, 64'h8000, 1'b0, 1'b0, LAT_MUL);

        applyStimulus("mul_1p5x2", 2'b10, 64'hC000, 64'h10000, 64'h18000, 1'b0, 1'b0, LAT_MUL);
        repeat (9) @(posedge clk);
        #1 begin
            start = 1'b1;
            op    = 2'b00;
            a     = 64'd1;
            b     = 64'd1;
        end
        @(posedge clk);
        #1 start = 1'b0;

        applyStimulus("mul_minexact", 2'b10, MINV, 64'h8000, MINV, 1'b0, 1'b0, LAT_MUL);
        applyStimulus("mul_negzero", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000, 64'd0, 1'b0, 1'b0, LAT_MUL);
        applyStimulus("div_signed", 2'b11, 64'hFFFF_FFFF_FFFE_8000, 64'h10000,
                      64'hFFFF_FFFF_FFFF_4000, 1'b0, 1'b0, LAT_DIV);
        applyStimulus("div_third", 2'b11, 64'h8000, 64'h18000, 64'h2AAA, 1'b0, 1'b0, LAT_DIV);
        applyStimulus("div_zero_pos", 2'b11, 64'h8000, 64'd0, MAXV, 1'b1, 1'b1, LAT_DIV);
        applyStimulus("div_zero_neg", 2'b11, 64'hFFFF_FFFF_FFFF_8000, 64'd0, MINV, 1'b1, 1'b1, LAT_DIV);
        applyStimulus("add_b2b", 2'b00, 64'h8000, 64'h8000, 64'h10000, 1'b0, 1'b0, LAT_ADD);

        waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
